// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: single-outstanding imem reads into a small
// PC-tagged FIFO feeding decode, with redirect flush and halt-after-ECALL.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [6:0]  part_of_inst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        halted
);
   localparam int         PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int         CW       = PW + 1;
   localparam logic [6:0] OP_ECALL = 7'b1110011;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_REQ_DROP, S_HALT} state_t;
   state_t r_state, w_state_nx;

   logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
   logic [31:0]   r_fifo_word [FIFO_DEPTH];
   logic [PW-1:0] r_rd_ptr, r_wr_ptr;
   logic [CW-1:0] r_cnt, w_cnt_nx;
   logic [31:0]   r_fetch_pc, w_fetch_pc_nx, r_addr;
   logic          r_req, r_halt_pend, w_halt_pend_nx;
   logic          w_done, w_pop, w_ecall, w_push, w_flush, w_space;
   logic          w_unused_rpc;

   assign w_unused_rpc = ^redirect_pc[1:0];

   assign w_done  = r_req && imem_ready;
   assign w_pop   = inst_valid && inst_ready;
   assign w_ecall = w_pop && !redirect && (inst[6:0] == OP_ECALL);
   // Only live (non-dropped) responses are pushed; an ECALL pop discards a same-cycle response
   assign w_push  = (r_state == S_REQ) && w_done && !redirect && !w_ecall;
   assign w_flush = redirect || w_ecall;

   always_comb begin
      w_cnt_nx = r_cnt;
      if (w_flush)
         w_cnt_nx = '0;
      else if (w_push && !w_pop)
         w_cnt_nx = r_cnt + CW'(1);
      else if (!w_push && w_pop)
         w_cnt_nx = r_cnt - CW'(1);
   end

   assign w_space = (w_cnt_nx < CW'(FIFO_DEPTH));

   always_comb begin
      w_state_nx     = r_state;
      w_halt_pend_nx = r_halt_pend;
      w_fetch_pc_nx  = r_fetch_pc;
      if (redirect) begin
         w_fetch_pc_nx  = {redirect_pc[31:2], 2'b00};
         w_halt_pend_nx = 1'b0;
         // FIFO is flushed here, so a fresh request always has room
         if (r_req && !imem_ready)
            w_state_nx = S_REQ_DROP;
         else
            w_state_nx = S_REQ;
      end else begin
         if (w_push)
            w_fetch_pc_nx = r_fetch_pc + 32'd4;
         case (r_state)
            S_IDLE: begin
               if (w_ecall)
                  w_state_nx = S_HALT;
               else if (w_space)
                  w_state_nx = S_REQ;
            end
            S_REQ: begin
               if (w_ecall) begin
                  w_state_nx     = imem_ready ? S_HALT : S_REQ_DROP;
                  w_halt_pend_nx = !imem_ready;
               end else if (w_done) begin
                  w_state_nx = w_space ? S_REQ : S_IDLE;
               end
            end
            S_REQ_DROP: begin
               if (w_done) begin
                  w_halt_pend_nx = 1'b0;
                  if (r_halt_pend)
                     w_state_nx = S_HALT;
                  else
                     w_state_nx = w_space ? S_REQ : S_IDLE;
               end
            end
            default: w_state_nx = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_req       <= 1'b0;
         r_addr      <= RESET_PC;
         r_fetch_pc  <= RESET_PC;
         r_halt_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_req       <= (w_state_nx == S_REQ) || (w_state_nx == S_REQ_DROP);
         r_fetch_pc  <= w_fetch_pc_nx;
         r_halt_pend <= w_halt_pend_nx;
         // Address only moves when a new request launches; REQ_DROP keeps the old one
         if (w_state_nx == S_REQ)
            r_addr <= w_fetch_pc_nx;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_cnt    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_pc[i]   <= '0;
            r_fifo_word[i] <= '0;
         end
      end else begin
         r_cnt <= w_cnt_nx;
         if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_push) begin
               r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
               r_fifo_word[r_wr_ptr] <= imem_rdata;
               r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + PW'(1);
         end
      end
   end

   assign imem_req     = r_req;
   assign imem_addr    = r_addr;
   assign inst_valid   = (r_cnt != '0);
   assign inst         = r_fifo_word[r_rd_ptr];
   assign inst_pc      = r_fifo_pc[r_rd_ptr];
   assign part_of_inst = inst[6:0];
   assign halted       = (r_state == S_HALT);

endmodule
